// File: rtl/mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bridge_pkg
// Purpose  : Shared types for the CPU memory bridge: core-side address and
//            response words, the bus-side signal bundles and a small helper
//            for word alignment.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_bridge_pkg;

   localparam int c_ADDR_W = 32;
   localparam int c_DATA_W = 32;

   // Core request payload (byte address) and core response payload (read word)
   typedef logic [c_ADDR_W-1:0] addr_t;
   typedef logic [c_DATA_W-1:0] mtrans_t;

   // Bridge-driven half of the pipelined memory bus
   typedef struct packed {
      logic  req;
      addr_t addr;
   } mem_bus_t;

   // Memory-driven half of the pipelined memory bus
   typedef struct packed {
      logic    gnt;
      logic    rvalid;
      mtrans_t rdata;
   } mem_bus_rsp_t;

   // The bus only ever sees word addresses; byte offset bits are cleared
   function automatic addr_t f_word_align(input addr_t i_addr);
      return {i_addr[c_ADDR_W-1:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bridge_if
// Purpose  : Signal bundle around the bridge: decoupled core request
//            (req_*), decoupled core response (resp_*), the pipelined memory
//            bus (bus / bus_rsp) and the sticky protocol-error flag.
// Modports : master - the bridge itself (consumes req, produces resp,
//                     drives the bus request side)
//            slave  - the surrounding system (core + memory)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_bridge_if;
   import mem_bridge_pkg::*;

   // Core request (decoupled, into the bridge)
   logic         req_valid;
   logic         req_ready;
   addr_t        req_data;

   // Core response (decoupled, out of the bridge)
   logic         resp_valid;
   logic         resp_ready;
   mtrans_t      resp_data;

   // Memory bus
   mem_bus_t     bus;
   mem_bus_rsp_t bus_rsp;
   logic         bus_proto_err;

   modport master (
      input  req_valid,
      input  req_data,
      output req_ready,
      output resp_valid,
      output resp_data,
      input  resp_ready,
      output bus,
      input  bus_rsp,
      output bus_proto_err
   );

   modport slave (
      output req_valid,
      output req_data,
      input  req_ready,
      input  resp_valid,
      input  resp_data,
      output resp_ready,
      input  bus,
      output bus_rsp,
      input  bus_proto_err
   );

endinterface
`default_nettype wire

// File: rtl/mem_bridge_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mem_bridge_fifo
// Purpose  : Synchronous FIFO of arbitrary depth (pointers wrap modulo
//            DEPTH, so non-power-of-two depths work) with registered storage
//            and an exposed occupancy count.
// Params   : WIDTH - data width, DEPTH - number of entries (>= 1)
// Ports    : clk      in  clock
//            rst      in  synchronous reset, active low
//            i_push   in  write i_wdata this cycle
//            i_wdata  in  write data
//            i_pop    in  discard the head entry this cycle
//            o_rdata  out head entry (valid when o_occ != 0)
//            o_occ    out number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
module mem_bridge_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic [$clog2(DEPTH+1)-1:0] o_occ
);

   // A depth-1 FIFO still needs a one-bit pointer
   localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_OW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_PW-1:0]  r_wr_ptr;
   logic [c_PW-1:0]  r_rd_ptr;
   logic [c_OW-1:0]  r_occ;

   function automatic logic [c_PW-1:0] f_wrap_inc(input logic [c_PW-1:0] i_ptr);
      return (int'(i_ptr) == DEPTH - 1) ? '0 : i_ptr + c_PW'(1);
   endfunction

   // Storage needs no reset: occupancy decides what is meaningful
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         a_no_overflow : assert (!(i_push && (r_occ == c_OW'(DEPTH))));
         a_no_underflow: assert (!(i_pop && (r_occ == '0)));
         if (i_push) begin
            r_wr_ptr <= f_wrap_inc(r_wr_ptr);
         end
         if (i_pop) begin
            r_rd_ptr <= f_wrap_inc(r_rd_ptr);
         end
         case ({i_push, i_pop})
            2'b10:   r_occ <= r_occ + c_OW'(1);
            2'b01:   r_occ <= r_occ - c_OW'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_occ   = r_occ;

endmodule
`default_nettype wire

// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mem_bridge
// Purpose  : Bridges the core's decoupled memory request/response pair onto
//            a pipelined req/gnt/rvalid memory bus. Counts granted-but-not-
//            returned transactions and only issues a request when the
//            response FIFO is guaranteed room for its data, so the core's
//            response back-pressure never stalls the bus.
// Params   : MAX_OUTSTANDING - max granted requests awaiting rvalid (>= 1)
//            RESP_DEPTH      - response FIFO entries (>= MAX_OUTSTANDING)
// Ports    : clk     in  clock, all logic on posedge
//            rst     in  synchronous reset, active low (0 = reset)
//            io_mem  --  mem_bridge_if.master: req/resp decoupled pair,
//                        bus request/address, bus gnt/rvalid/rdata and the
//                        sticky bus_proto_err flag
// Config   : MEM_BRIDGE_BYPASS_EN - when defined, read data arriving on an
//            empty FIFO with resp_ready high is forwarded combinationally
//            (response in the rvalid cycle). Undefined: every response goes
//            through the FIFO (one cycle later). Credit rule is the same.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bridge
   import mem_bridge_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int RESP_DEPTH      = 2
) (
   input  logic         clk,
   input  logic         rst,
   mem_bridge_if.master io_mem
);

   localparam int c_IW = $clog2(MAX_OUTSTANDING + 1);
   localparam int c_OW = $clog2(RESP_DEPTH + 1);

   logic [c_IW-1:0] r_inflight;
   logic            r_proto_err;

   logic [c_OW-1:0] w_occ;
   mtrans_t         w_head;
   logic            w_credit;
   logic            w_bus_req;
   logic            w_fire;
   logic            w_rv_ok;
   logic            w_bypass;
   logic            w_push;
   logic            w_pop;
   logic            w_fifo_nempty;
   mem_bus_t        w_bus;

   // Every granted request reserves a FIFO slot until its data is popped,
   // so the FIFO can never be asked to hold more than it has.
   assign w_credit = ((int'(r_inflight) + int'(w_occ)) < RESP_DEPTH) &&
                     (int'(r_inflight) < MAX_OUTSTANDING);

   assign w_bus_req = io_mem.req_valid && w_credit && rst;
   assign w_fire    = w_bus_req && io_mem.bus_rsp.gnt;

   // rvalid only counts when something is actually outstanding
   assign w_rv_ok   = io_mem.bus_rsp.rvalid && (r_inflight != '0);

   assign w_fifo_nempty = (w_occ != '0);

`ifdef MEM_BRIDGE_BYPASS_EN
   assign w_bypass = rst && !w_fifo_nempty && w_rv_ok && io_mem.resp_ready;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push = w_rv_ok && !w_bypass;
   assign w_pop  = rst && io_mem.resp_ready && w_fifo_nempty;

   always_comb begin
      w_bus      = '0;
      w_bus.req  = w_bus_req;
      w_bus.addr = f_word_align(io_mem.req_data);
   end

   assign io_mem.bus           = w_bus;
   assign io_mem.req_ready     = io_mem.bus_rsp.gnt && w_credit && rst;
   assign io_mem.resp_valid    = rst && (w_fifo_nempty || w_bypass);
   assign io_mem.resp_data     = w_fifo_nempty ? w_head : io_mem.bus_rsp.rdata;
   assign io_mem.bus_proto_err = r_proto_err;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_inflight  <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_fire && !w_rv_ok) begin
            r_inflight <= r_inflight + c_IW'(1);
         end else if (w_rv_ok && !w_fire) begin
            r_inflight <= r_inflight - c_IW'(1);
         end
         // Data returned with nothing outstanding is dropped and flagged
         if (io_mem.bus_rsp.rvalid && (r_inflight == '0)) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   mem_bridge_fifo #(
      .WIDTH (c_DATA_W),
      .DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (io_mem.bus_rsp.rdata),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_occ   (w_occ)
   );

endmodule
`default_nettype wire

// File: tb/tb_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bridge
// Purpose  : Directed self-checking bench for mem_bridge with default
//            parameters (MAX_OUTSTANDING=2, RESP_DEPTH=2). Expectations
//            follow MEM_BRIDGE_BYPASS_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bridge;
   import mem_bridge_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_bridge_if u_if ();

   mem_bridge #(
      .MAX_OUTSTANDING (2),
      .RESP_DEPTH      (2)
   ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_mem (u_if)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge, outputs are sampled
   // 4 units after it, well clear of both clock edges.
   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic set_idle();
      u_if.req_valid      = 1'b0;
      u_if.req_data       = '0;
      u_if.resp_ready     = 1'b0;
      u_if.bus_rsp.gnt    = 1'b0;
      u_if.bus_rsp.rvalid = 1'b0;
      u_if.bus_rsp.rdata  = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int   issued;
      int   delivered;
      int   rd_idx;
      int   cyc;
      logic pend;

      // ---------------- reset with a pending request ----------------
      rst = 1'b0;
      set_idle();
      u_if.req_valid = 1'b1;
      u_if.req_data  = 32'h0000_0100;
      for (int i = 0; i < 3; i++) begin
         next_cyc();
         settle();
         chk("rst_bus_req",    {31'd0, u_if.bus.req},       32'd0);
         chk("rst_resp_valid", {31'd0, u_if.resp_valid},    32'd0);
         chk("rst_proto_err",  {31'd0, u_if.bus_proto_err}, 32'd0);
      end
      next_cyc();
      rst = 1'b1;
      settle();
      chk("post_rst_bus_req",   {31'd0, u_if.bus.req},   32'd1);
      chk("post_rst_req_ready", {31'd0, u_if.req_ready}, 32'd0);

      // ---------------- single read ----------------
      next_cyc();
      u_if.req_data    = 32'h8000_0006;
      u_if.bus_rsp.gnt = 1'b1;
      u_if.resp_ready  = 1'b1;
      settle();
      chk("single_bus_addr",  u_if.bus.addr,              32'h8000_0004);
      chk("single_req_ready", {31'd0, u_if.req_ready},    32'd1);
      next_cyc();
      u_if.req_valid   = 1'b0;
      u_if.bus_rsp.gnt = 1'b0;
      settle();
      chk("single_wait_valid", {31'd0, u_if.resp_valid}, 32'd0);
      next_cyc();
      u_if.bus_rsp.rvalid = 1'b1;
      u_if.bus_rsp.rdata  = 32'hDEAD_BEEF;
      settle();
`ifdef MEM_BRIDGE_BYPASS_EN
      chk("single_byp_valid", {31'd0, u_if.resp_valid}, 32'd1);
      chk("single_byp_data",  u_if.resp_data,           32'hDEAD_BEEF);
`else
      chk("single_rv_valid",  {31'd0, u_if.resp_valid}, 32'd0);
`endif
      next_cyc();
      u_if.bus_rsp.rvalid = 1'b0;
      u_if.bus_rsp.rdata  = '0;
      settle();
`ifdef MEM_BRIDGE_BYPASS_EN
      chk("single_byp_after", {31'd0, u_if.resp_valid}, 32'd0);
`else
      chk("single_valid",     {31'd0, u_if.resp_valid}, 32'd1);
      chk("single_data",      u_if.resp_data,           32'hDEAD_BEEF);
`endif
      next_cyc();
      settle();
      chk("single_drained", {31'd0, u_if.resp_valid}, 32'd0);

      // ---------------- back-pressure: 3 requests, resp_ready low ----------
      next_cyc();
      u_if.resp_ready  = 1'b0;
      u_if.bus_rsp.gnt = 1'b1;
      u_if.req_valid   = 1'b1;
      u_if.req_data    = 32'h0000_1000;
      settle();
      chk("bp_req0_ready", {31'd0, u_if.req_ready}, 32'd1);
      next_cyc();
      u_if.req_data = 32'h0000_1004;
      settle();
      chk("bp_req1_ready", {31'd0, u_if.req_ready}, 32'd1);
      next_cyc();
      u_if.req_data       = 32'h0000_1008;
      u_if.bus_rsp.rvalid = 1'b1;
      u_if.bus_rsp.rdata  = 32'h1111_0000;
      settle();
      chk("bp_req2_stall",   {31'd0, u_if.req_ready}, 32'd0);
      chk("bp_bus_req_low",  {31'd0, u_if.bus.req},   32'd0);
      next_cyc();
      u_if.bus_rsp.rdata = 32'h2222_0000;
      settle();
      chk("bp_stall_c4",  {31'd0, u_if.req_ready},  32'd0);
      chk("bp_valid_c4",  {31'd0, u_if.resp_valid}, 32'd1);
      chk("bp_data_c4",   u_if.resp_data,           32'h1111_0000);
      next_cyc();
      u_if.bus_rsp.rvalid = 1'b0;
      u_if.resp_ready     = 1'b1;
      settle();
      chk("bp_stall_c5",   {31'd0, u_if.req_ready},  32'd0);
      chk("bp_stable_c5",  u_if.resp_data,           32'h1111_0000);
      next_cyc();
      settle();
      chk("bp_req2_go",    {31'd0, u_if.req_ready},  32'd1);
      chk("bp_req2_addr",  u_if.bus.addr,            32'h0000_1008);
      chk("bp_valid_c6",   {31'd0, u_if.resp_valid}, 32'd1);
      chk("bp_data_c6",    u_if.resp_data,           32'h2222_0000);
      next_cyc();
      u_if.req_valid      = 1'b0;
      u_if.bus_rsp.gnt    = 1'b0;
      u_if.bus_rsp.rvalid = 1'b1;
      u_if.bus_rsp.rdata  = 32'h3333_0000;
      settle();
`ifdef MEM_BRIDGE_BYPASS_EN
      chk("bp_byp_valid_c7", {31'd0, u_if.resp_valid}, 32'd1);
      chk("bp_byp_data_c7",  u_if.resp_data,           32'h3333_0000);
`else
      chk("bp_valid_c7",     {31'd0, u_if.resp_valid}, 32'd0);
`endif
      next_cyc();
      u_if.bus_rsp.rvalid = 1'b0;
      settle();
`ifdef MEM_BRIDGE_BYPASS_EN
      chk("bp_byp_valid_c8", {31'd0, u_if.resp_valid}, 32'd0);
`else
      chk("bp_valid_c8",     {31'd0, u_if.resp_valid}, 32'd1);
      chk("bp_data_c8",      u_if.resp_data,           32'h3333_0000);
`endif
      next_cyc();
      settle();
      chk("bp_drained", {31'd0, u_if.resp_valid}, 32'd0);

      // ---------------- streaming: grant every cycle, rvalid one cycle later
      issued          = 0;
      delivered       = 0;
      rd_idx          = 0;
      cyc             = 0;
      pend            = 1'b0;
      u_if.resp_ready = 1'b1;
      while ((delivered < 10) && (cyc < 100)) begin
         next_cyc();
         cyc++;
         u_if.bus_rsp.gnt    = 1'b1;
         u_if.req_valid      = (issued < 10);
         u_if.req_data       = 32'h0000_2000 + 32'(issued * 4);
         u_if.bus_rsp.rvalid = pend;
         u_if.bus_rsp.rdata  = 32'hC0DE_0000 + 32'(rd_idx);
         settle();
         if (pend) begin
            rd_idx++;
         end
         pend = u_if.bus.req && u_if.bus_rsp.gnt;
         if (pend) begin
            chk("stream_addr", u_if.bus.addr, 32'h0000_2000 + 32'(issued * 4));
            issued++;
         end
         if (u_if.resp_valid && u_if.resp_ready) begin
            chk("stream_data", u_if.resp_data, 32'hC0DE_0000 + 32'(delivered));
            delivered++;
         end
      end
      chk("stream_count", 32'(delivered), 32'd10);
      next_cyc();
      set_idle();
      u_if.resp_ready = 1'b1;
      settle();
      chk("stream_no_extra", {31'd0, u_if.resp_valid}, 32'd0);

      // ---------------- spurious rvalid ----------------
      next_cyc();
      u_if.bus_rsp.rvalid = 1'b1;
      u_if.bus_rsp.rdata  = 32'hBAD0_BAD0;
      settle();
      chk("spur_err_same",   {31'd0, u_if.bus_proto_err}, 32'd0);
      chk("spur_valid_same", {31'd0, u_if.resp_valid},    32'd0);
      next_cyc();
      u_if.bus_rsp.rvalid = 1'b0;
      settle();
      chk("spur_err",        {31'd0, u_if.bus_proto_err}, 32'd1);
      chk("spur_valid",      {31'd0, u_if.resp_valid},    32'd0);
      repeat (3) next_cyc();
      settle();
      chk("spur_err_sticky", {31'd0, u_if.bus_proto_err}, 32'd1);
      next_cyc();
      rst = 1'b0;
      settle();
      next_cyc();
      rst = 1'b1;
      settle();
      chk("spur_err_cleared", {31'd0, u_if.bus_proto_err}, 32'd0);

      // ---------------- reset mid-operation ----------------
      next_cyc();
      u_if.resp_ready  = 1'b0;
      u_if.req_valid   = 1'b1;
      u_if.bus_rsp.gnt = 1'b1;
      u_if.req_data    = 32'h0000_3000;
      settle();
      chk("rm_req0_ready", {31'd0, u_if.req_ready}, 32'd1);
      next_cyc();
      u_if.req_data = 32'h0000_3004;
      settle();
      chk("rm_req1_ready", {31'd0, u_if.req_ready}, 32'd1);
      next_cyc();
      u_if.req_valid      = 1'b0;
      u_if.bus_rsp.gnt    = 1'b0;
      u_if.bus_rsp.rvalid = 1'b1;
      u_if.bus_rsp.rdata  = 32'h4444_0000;
      settle();
      next_cyc();
      u_if.bus_rsp.rvalid = 1'b0;
      settle();
      chk("rm_buffered_valid", {31'd0, u_if.resp_valid}, 32'd1);
      chk("rm_buffered_data",  u_if.resp_data,           32'h4444_0000);
      next_cyc();
      rst = 1'b0;
      settle();
      chk("rm_in_rst_valid", {31'd0, u_if.resp_valid}, 32'd0);
      next_cyc();
      rst                 = 1'b1;
      u_if.bus_rsp.rvalid = 1'b1;
      u_if.bus_rsp.rdata  = 32'h5555_0000;
      settle();
      chk("rm_after_valid",  {31'd0, u_if.resp_valid},    32'd0);
      chk("rm_err_not_yet",  {31'd0, u_if.bus_proto_err}, 32'd0);
      next_cyc();
      u_if.bus_rsp.rvalid = 1'b0;
      settle();
      chk("rm_late_err",     {31'd0, u_if.bus_proto_err}, 32'd1);
      chk("rm_late_valid",   {31'd0, u_if.resp_valid},    32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
